// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: FSM encoding, shift-mode codes
// and default operand widths.
package shift_sequencer_pkg;

    localparam int DEFAULT_WIDTH  = 4;
    localparam int DEFAULT_DIST_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Code 2'b11 is reserved and decodes as a logical right shift.
    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;
    localparam logic [1:0] MODE_LSL = 2'b10;

endpackage

// File: rtl/shift_sequencer_shift_step.sv
// Single-bit shift of the working register; the mode selects direction and
// the fill bit.
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value_in,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] value_out
);

    always_comb begin
        value_out = {1'b0, value_in[WIDTH-1:1]};
        case (mode)
            MODE_ASR: value_out = {value_in[WIDTH-1], value_in[WIDTH-1:1]};
            MODE_LSL: value_out = {value_in[WIDTH-2:0], 1'b0};
            default:  value_out = {1'b0, value_in[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: accepts a request while idle, shifts one bit per
// cycle, then presents the final value with a one-cycle done pulse.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIST_W = DEFAULT_DIST_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  value_in,
    input  logic [DIST_W-1:0] distance,
    input  logic [1:0]        mode,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   step_out;
    logic [CNT_W-1:0]   sat_count;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .value_in  (work_q),
        .mode      (mode_q),
        .value_out (step_out)
    );

    // Distances of WIDTH or more all produce the WIDTH-step result.
    always_comb begin
        if (32'(distance) >= 32'(WIDTH)) begin
            sat_count = CNT_W'(WIDTH);
        end else begin
            sat_count = CNT_W'(distance);
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        work_d   = work_q;
        result_d = result_q;
        mode_d   = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = value_in;
                    mode_d  = mode;
                    count_d = sat_count;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (count_q != '0) begin
                    work_d  = step_out;
                    count_d = count_q - CNT_W'(1);
                end else begin
                    // Only the finished value ever reaches the result register.
                    result_d = work_q;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            work_q   <= '0;
            result_q <= '0;
            mode_q   <= MODE_LSR;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            work_q   <= work_d;
            result_q <= result_d;
            mode_q   <= mode_d;
        end
    end

    assign ready  = (state_q == ST_IDLE);
    assign busy   = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: a driver queues expected results and
// done cycles, a negedge monitor checks handshake, timing and result.
module tb_shift_sequencer;

    localparam int W  = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  value_in = '0;
    logic [DW-1:0] distance = '0;
    logic [1:0]    mode = '0;
    logic          ready, busy, done;
    logic [W-1:0]  result;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] held = '0;

    shift_sequencer #(.WIDTH(W), .DIST_W(DW)) dut (
        .clock    (clk),
        .reset_n  (reset_n),
        .start    (start),
        .value_in (value_in),
        .distance (distance),
        .mode     (mode),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference behaviour: whole-word shift by the saturated distance.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input int d,
                                               input logic [1:0] m);
        int                  k;
        logic signed [W-1:0] sv;
        k  = (d > W) ? W : d;
        sv = v;
        case (m)
            2'b01:   return W'(sv >>> k);
            2'b10:   return W'(v << k);
            default: return W'(v >> k);
        endcase
    endfunction

    // Monitor: expected ready/busy/done follow from the scoreboard queue.
    always @(negedge clk) begin
        if (!reset_n) begin
            held = '0;
        end else begin
            bit exp_idle;
            bit exp_done;
            exp_idle = (sbq.size() == 0);
            exp_done = (sbq.size() > 0) && (cyc == sbq[0].cyc);
            chk("ready", ready, exp_idle);
            chk("busy", busy, !exp_idle);
            chk("done", done, exp_done);
            if (sbq.size() > 0 && (done || cyc >= sbq[0].cyc)) begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", result, e.res);
                held = e.res;
            end else if (ready && !done) begin
                chk("result_hold", result, held);
            end
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (!ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    // One request; hammer keeps start asserted while the block is busy.
    task automatic do_req(input logic [W-1:0] v, input logic [DW-1:0] d,
                          input logic [1:0] m, input bit hammer);
        exp_t e;
        int   t;
        wait_ready();
        start    = 1'b1;
        value_in = v;
        distance = d;
        mode     = m;
        e.res    = ref_shift(v, int'(d), m);
        e.cyc    = cyc + 1 + ((int'(d) > W) ? W : int'(d)) + 1;
        @(posedge clk);
        sbq.push_back(e);
        #1;
        t = 0;
        while (hammer && busy && t < 20) begin
            value_in = W'($urandom);
            distance = DW'($urandom);
            mode     = 2'($urandom);
            @(posedge clk);
            #1;
            t++;
        end
        start    = 1'b0;
        value_in = W'($urandom);
        distance = DW'($urandom);
        mode     = 2'($urandom);
    endtask

    initial begin
        exp_t e;
        int   t;
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;

        do_req(4'b0110, 4'd2, 2'b00, 1'b0);
        do_req(4'b1010, 4'd2, 2'b01, 1'b0);
        do_req(4'b1010, 4'd2, 2'b00, 1'b0);
        do_req(4'b1000, 4'd9, 2'b01, 1'b0);
        do_req(4'b1000, 4'd9, 2'b10, 1'b0);
        do_req(4'b0011, 4'd0, 2'b00, 1'b0);
        do_req(4'b0011, 4'd1, 2'b10, 1'b0);
        do_req(4'b0101, 4'd3, 2'b00, 1'b1);
        do_req(4'b1001, 4'd15, 2'b11, 1'b0);

        // Abort a distance-4 request two cycles in; no done may follow.
        wait_ready();
        start    = 1'b1;
        value_in = 4'b1101;
        distance = 4'd4;
        mode     = 2'b00;
        @(posedge clk);
        e.res = '0;
        e.cyc = 32'h7fff_ffff;
        sbq.push_back(e);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        sbq.delete();
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        // First edge after release must accept.
        do_req(4'b0111, 4'd1, 2'b10, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_req(W'($urandom), DW'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        t = 0;
        while (sbq.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sbq.size(), 0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
